// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//                common items : u64/u32 types, PCINIT reset fetch address.
//                pipes items  : fetch_data_t (pc, instruction) handed to
//                               decode, fetch_state_t fetch FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

   typedef logic [63:0] u64;
   typedef logic [31:0] u32;

   // Default first fetch address after reset.
   localparam u64 PCINIT = 64'h8000_0000;

   // Every instruction is 4 bytes; the pc advances by this amount.
   localparam u64 c_instr_bytes = 64'd4;

   typedef struct packed {
      u64 pc;
      u32 instruction;
   } fetch_data_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // no request on the bus
      FETCH = 2'd1,   // request outstanding, its data is wanted
      FLUSH = 2'd2    // request outstanding, its data will be dropped
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Bundles the fetch stage's instruction-bus handshake, the
//                decode-side output slot and the execute-side redirect.
//                master : the fetch stage (drives ireq_*, dataF, validF)
//                slave  : bus / decode / execute side of the same signals
//  Ports       : ireq_valid, ireq_addr      - fetch request
//                iresp_data_ok, iresp_data  - fetch response
//                stall                      - decode back-pressure
//                redirect, redirect_pc      - pc redirect from execute
//                dataF, validF              - instruction slot to decode
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic        ireq_valid;
   u64          ireq_addr;
   logic        iresp_data_ok;
   u32          iresp_data;
   logic        stall;
   logic        redirect;
   u64          redirect_pc;
   fetch_data_t dataF;
   logic        validF;

   modport master (
      output ireq_valid,
      output ireq_addr,
      input  iresp_data_ok,
      input  iresp_data,
      input  stall,
      input  redirect,
      input  redirect_pc,
      output dataF,
      output validF
   );

   modport slave (
      input  ireq_valid,
      input  ireq_addr,
      output iresp_data_ok,
      output iresp_data,
      output stall,
      output redirect,
      output redirect_pc,
      input  dataF,
      input  validF
   );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_pcselect.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pcselect
//  Description : Combinational next-pc selection for the fetch stage.
//                Priority: redirect target, then pc+4 (64-bit wrap) when an
//                instruction is accepted, otherwise hold.
//  Ports       : i_pc          - current program counter
//                i_redirect    - redirect from execute
//                i_redirect_pc - redirect target
//                i_advance     - current pc's instruction accepted this cycle
//                o_next_pc     - pc for the next cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage_pcselect
   import fetch_stage_pkg::*;
(
   input  u64   i_pc,
   input  logic i_redirect,
   input  u64   i_redirect_pc,
   input  logic i_advance,
   output u64   o_next_pc
);

   always_comb begin
      o_next_pc = i_pc;
      if (i_redirect) begin
         o_next_pc = i_redirect_pc;
      end else if (i_advance) begin
         o_next_pc = i_pc + c_instr_bytes;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Owns the pc, runs the instruction
//                bus request/response handshake and presents a registered
//                {pc, instruction} slot plus valid flag to decode. Honours
//                decode stall and execute redirect, dropping the data of any
//                request made obsolete by a redirect.
//                Optional macro FETCH_SKID_EN adds a one-entry skid buffer
//                behind dataF, allowing one instruction per cycle.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous active-high reset
//                bus   - fetch_stage_if.master (bus, decode, redirect)
//  Parameters  : PC_RESET - first fetch address after reset
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter u64 PC_RESET = PCINIT
)(
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   u64          r_pc;        // next address to fetch (redirect lands here)
   u64          r_req_addr;  // address of the request on the bus
   fetch_data_t r_data;
   logic        r_valid;

   u64          w_next_pc;
   logic        w_accept;    // bus data taken as a real instruction
   logic        w_start_req; // a new request begins next cycle
   logic        w_consume;   // decode takes dataF at this edge
   logic        w_slot_free; // dataF can be overwritten at this edge
   logic        w_can_start;
   fetch_data_t w_new;

`ifdef FETCH_SKID_EN
   fetch_data_t r_skid_data;
   logic        r_skid_valid;
`endif

   assign w_consume   = r_valid && !bus.stall;
   assign w_slot_free = !r_valid || !bus.stall;
   assign w_new       = '{pc: r_req_addr, instruction: bus.iresp_data};

`ifdef FETCH_SKID_EN
   // A fetch may start as long as the skid will be empty after this edge,
   // since an arrival can always land in either dataF or the skid.
   assign w_can_start = !r_skid_valid || w_consume;
`else
   // Without a skid the arriving instruction must have dataF to land in.
   assign w_can_start = w_slot_free;
`endif

   fetch_stage_pcselect u_pcselect (
      .i_pc          (r_pc),
      .i_redirect    (bus.redirect),
      .i_redirect_pc (bus.redirect_pc),
      .i_advance     (w_accept),
      .o_next_pc     (w_next_pc)
   );

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and control
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_start_req  = 1'b0;
      case (r_state)
         IDLE: begin
            // A redirect here only moves pc; fetching resumes next cycle.
            if (!bus.redirect && w_can_start) begin
               w_state_next = FETCH;
               w_start_req  = 1'b1;
            end
         end
         FETCH: begin
            if (bus.redirect) begin
               w_state_next = bus.iresp_data_ok ? IDLE : FLUSH;
            end else if (bus.iresp_data_ok) begin
               w_accept = 1'b1;
`ifdef FETCH_SKID_EN
               // Keep streaming unless this instruction is parked in skid.
               if (w_slot_free) begin
                  w_start_req = 1'b1;
               end else begin
                  w_state_next = IDLE;
               end
`else
               w_state_next = IDLE;
`endif
            end
         end
         FLUSH: begin
            // Old request stays on the bus until answered; its data is lost.
            if (bus.iresp_data_ok) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // pc, request address and output slot(s)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc         <= PC_RESET;
         r_req_addr   <= PC_RESET;
         r_data       <= '0;
         r_valid      <= 1'b0;
`ifdef FETCH_SKID_EN
         r_skid_data  <= '0;
         r_skid_valid <= 1'b0;
`endif
      end else begin
         r_pc <= w_next_pc;
         if (w_start_req) begin
            r_req_addr <= w_next_pc;
         end
         if (bus.redirect) begin
            r_valid      <= 1'b0;
`ifdef FETCH_SKID_EN
            r_skid_valid <= 1'b0;
`endif
         end else begin
`ifdef FETCH_SKID_EN
            if (w_accept && w_slot_free) begin
               r_data  <= w_new;
               r_valid <= 1'b1;
            end else if (w_accept) begin
               r_skid_data  <= w_new;
               r_skid_valid <= 1'b1;
            end else if (w_consume) begin
               if (r_skid_valid) begin
                  r_data       <= r_skid_data;
                  r_skid_valid <= 1'b0;
               end else begin
                  r_valid <= 1'b0;
               end
            end
`else
            if (w_accept) begin
               r_data  <= w_new;
               r_valid <= 1'b1;
            end else if (w_consume) begin
               r_valid <= 1'b0;
            end
`endif
         end
      end
   end

   assign bus.ireq_valid = (r_state != IDLE);
   assign bus.ireq_addr  = r_req_addr;
   assign bus.dataF      = r_data;
   assign bus.validF     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A table of per-cycle
//                {bus/stall/redirect inputs, expected outputs} records is
//                applied on the falling edge, followed by a hand-written
//                asynchronous reset sequence in the middle of a fetch.
//                Builds with or without FETCH_SKID_EN select the matching
//                table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   fetch_stage_if bus_if ();

   fetch_stage #(.PC_RESET(64'h8000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        ok;
      logic [31:0] rdata;
      logic        stall;
      logic        redir;
      logic [63:0] rpc;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_valid;
      logic [63:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vecs[$];

   localparam logic [63:0] B = 64'h8000_0000;

   function automatic vec_t mk(input logic ok, input logic [31:0] rdata,
                               input logic stall, input logic redir,
                               input logic [63:0] rpc, input logic e_req,
                               input logic [63:0] e_addr, input logic e_valid,
                               input logic [63:0] e_pc, input logic [31:0] e_instr);
      vec_t v;
      v.ok = ok;       v.rdata = rdata;   v.stall = stall;
      v.redir = redir; v.rpc = rpc;       v.e_req = e_req;
      v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_pc = e_pc;   v.e_instr = e_instr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ok, input logic [31:0] rdata, input logic stall,
                        input logic redir, input logic [63:0] rpc);
      bus_if.iresp_data_ok = ok;
      bus_if.iresp_data    = rdata;
      bus_if.stall         = stall;
      bus_if.redirect      = redir;
      bus_if.redirect_pc   = rpc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);

      //            ok rdata          st rd rpc                    | req addr                   vF pc                    instr
`ifdef FETCH_SKID_EN
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(1, 32'h0000_0013,  0, 0, 64'h0,          1, B,       0, 64'h0,   32'h0));
      vecs.push_back(mk(1, 32'h0010_0093,  0, 0, 64'h0,          1, B+4,     1, B,       32'h0000_0013));
      vecs.push_back(mk(1, 32'h0020_0113,  1, 0, 64'h0,          1, B+8,     1, B+4,     32'h0010_0093));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   1, B+4,     32'h0010_0093));
      vecs.push_back(mk(1, 32'h0030_0193,  0, 0, 64'h0,          1, B+12,    1, B+8,     32'h0020_0113));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          1, B+16,    1, B+12,    32'h0030_0193));
      vecs.push_back(mk(1, 32'hDEAD_BEEF,  0, 1, B+64'h100,      1, B+16,    0, 64'h0,   32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          1, B+64'h100, 0, 64'h0, 32'h0));
`else
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(1, 32'h0000_0013,  0, 0, 64'h0,          1, B,       0, 64'h0,   32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   1, B,       32'h0000_0013));
      vecs.push_back(mk(1, 32'h0010_0093,  0, 0, 64'h0,          1, B+4,     0, 64'h0,   32'h0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0, 32'h0,       1, 0, 64'h0,          0, 64'h0,   1, B+4,     32'h0010_0093));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   1, B+4,     32'h0010_0093));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          1, B+8,     0, 64'h0,   32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 1, B+64'h100,      1, B+8,     0, 64'h0,   32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          1, B+8,     0, 64'h0,   32'h0));
      vecs.push_back(mk(1, 32'hDEAD_BEEF,  0, 0, 64'h0,          1, B+8,     0, 64'h0,   32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(1, 32'h0020_0113,  0, 0, 64'h0,          1, B+64'h100, 0, 64'h0, 32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   1, B+64'h100, 32'h0020_0113));
      vecs.push_back(mk(1, 32'h0BAD_C0DE,  0, 1, B+64'h200,      1, B+64'h104, 0, 64'h0, 32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(1, 32'h0030_0193,  0, 0, 64'h0,          1, B+64'h200, 0, 64'h0, 32'h0));
      vecs.push_back(mk(0, 32'h0,          1, 1, B+64'h300,      0, 64'h0,   1, B+64'h200, 32'h0030_0193));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          1, B+64'h300, 0, 64'h0, 32'h0));
      vecs.push_back(mk(1, 32'h0040_0213,  0, 0, 64'h0,          1, B+64'h300, 0, 64'h0, 32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 1, B+64'h300, 32'h0040_0213));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(1, 32'h0050_0293,  0, 0, 64'h0,          1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0050_0293));
      vecs.push_back(mk(0, 32'h0,          0, 1, B+64'h400,      1, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 1, B+64'h500,      1, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(1, 32'h1111_1111,  0, 0, 64'h0,          1, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   0, 64'h0,   32'h0));
      vecs.push_back(mk(1, 32'h0060_0313,  0, 0, 64'h0,          1, B+64'h500, 0, 64'h0, 32'h0));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          0, 64'h0,   1, B+64'h500, 32'h0060_0313));
      vecs.push_back(mk(0, 32'h0,          0, 0, 64'h0,          1, B+64'h504, 0, 64'h0, 32'h0));
`endif

      // Values held while reset is asserted.
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ireq_valid", {63'h0, bus_if.ireq_valid}, 64'h0);
      chk("rst.ireq_addr",  bus_if.ireq_addr, B);
      chk("rst.validF",     {63'h0, bus_if.validF}, 64'h0);
      chk("rst.dataF.pc",   bus_if.dataF.pc, 64'h0);
      chk("rst.dataF.instr", {32'h0, bus_if.dataF.instruction}, 64'h0);

      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         chk($sformatf("v%0d.ireq_valid", i), {63'h0, bus_if.ireq_valid}, {63'h0, vecs[i].e_req});
         if (vecs[i].e_req)
            chk($sformatf("v%0d.ireq_addr", i), bus_if.ireq_addr, vecs[i].e_addr);
         chk($sformatf("v%0d.validF", i), {63'h0, bus_if.validF}, {63'h0, vecs[i].e_valid});
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d.dataF.pc", i), bus_if.dataF.pc, vecs[i].e_pc);
            chk($sformatf("v%0d.dataF.instr", i), {32'h0, bus_if.dataF.instruction},
                {32'h0, vecs[i].e_instr});
         end
         drive(vecs[i].ok, vecs[i].rdata, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
         @(negedge clk);
      end

      // Reset in the middle of an outstanding fetch, away from any rising edge.
      drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      chk("midrst.pre_ireq_valid", {63'h0, bus_if.ireq_valid}, 64'h1);
      reset = 1'b1;
      #1;
      chk("midrst.ireq_valid", {63'h0, bus_if.ireq_valid}, 64'h0);
      chk("midrst.ireq_addr",  bus_if.ireq_addr, B);
      chk("midrst.validF",     {63'h0, bus_if.validF}, 64'h0);
      chk("midrst.dataF.pc",   bus_if.dataF.pc, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      chk("restart.idle", {63'h0, bus_if.ireq_valid}, 64'h0);
      @(negedge clk);
      chk("restart.ireq_valid", {63'h0, bus_if.ireq_valid}, 64'h1);
      chk("restart.ireq_addr",  bus_if.ireq_addr, B);
      drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      chk("restart.validF",   {63'h0, bus_if.validF}, 64'h1);
      chk("restart.dataF.pc", bus_if.dataF.pc, B);
      chk("restart.dataF.instr", {32'h0, bus_if.dataF.instruction}, 64'h13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
